fft16_bitrev_loader: RTL and testbench

//  Input stage of the 16-point radix-2 DIT FFT. Accepts natural-order complex samples one per beat,

---
 rtl/fft16_pkg.sv | 28 ++
 rtl/fft16_pingpong_bank.sv | 29 ++
 rtl/fft16_bitrev_loader.sv | 126 ++++++++++++
 tb/tb_fft16_bitrev_loader.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/fft16_pkg.sv
// Shared constants and bit-reversal helpers for the 16-point radix-2 DIT FFT.
package fft16_pkg;

   localparam int unsigned N_DEF    = 16;
   localparam int unsigned Q_DEF    = 8;
   localparam int unsigned LOG2_PTS = 4;
   localparam int unsigned PTS      = 16;
   localparam int unsigned PAIRS    = PTS / 2;
   localparam int unsigned W0_RE    = 1 << Q_DEF;

   typedef enum logic {
      BANK0 = 1'b0,
      BANK1 = 1'b1
   } bank_e;

   function automatic logic [3:0] bitrev4(input logic [3:0] a);
      return {a[0], a[1], a[2], a[3]};
   endfunction

   function automatic logic [2:0] bitrev3(input logic [2:0] a);
      return {a[0], a[1], a[2]};
   endfunction

   function automatic bank_e other_bank(input bank_e b);
      return (b == BANK0) ? BANK1 : BANK0;
   endfunction

endpackage

// File: rtl/fft16_pingpong_bank.sv
// Two banks of 16 complex words: one synchronous write port, two combinational read ports.
module fft16_pingpong_bank #(
   parameter int unsigned W = 32
) (
   input  logic         i_clk,
   input  logic         i_we,
   input  logic         i_wbank,
   input  logic [3:0]   i_waddr,
   input  logic [W-1:0] i_wdata,
   input  logic         i_rbank,
   input  logic [3:0]   i_raddr0,
   input  logic [3:0]   i_raddr1,
   output logic [W-1:0] o_rdata0,
   output logic [W-1:0] o_rdata1
);

   // Storage is intentionally unreset; contents are don't-care until written.
   logic [W-1:0] mem_q [2][16];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         mem_q[i_wbank][i_waddr] <= i_wdata;
      end
   end

   assign o_rdata0 = mem_q[i_rbank][i_raddr0];
   assign o_rdata1 = mem_q[i_rbank][i_raddr1];

endmodule

// File: rtl/fft16_bitrev_loader.sv
// FFT16 input stage: ping-pong loads natural-order samples and emits bit-reversed operand pairs.
// Optional build macro FFT_LOADER_PRESCALE_EN halves each sample (arithmetic shift) on write.
module fft16_bitrev_loader
   import fft16_pkg::*;
#(
   parameter int unsigned N = N_DEF,
   parameter int unsigned Q = Q_DEF
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [N-1:0] i_re,
   input  logic [N-1:0] i_im,
   output logic         o_valid,
   input  logic         i_ready,
   output logic [N-1:0] o_in0_re,
   output logic [N-1:0] o_in0_im,
   output logic [N-1:0] o_in1_re,
   output logic [N-1:0] o_in1_im,
   output logic [N-1:0] o_twiddle_re,
   output logic [N-1:0] o_twiddle_im,
   output logic [2:0]   o_pair_idx,
   output logic         o_last
);

   localparam logic [N-1:0] W0_RE_L = N'(1) << Q;

   logic [3:0] wr_cnt_q, wr_cnt_d;
   logic [2:0] rd_cnt_q, rd_cnt_d;
   bank_e      wr_bank_q, wr_bank_d;
   bank_e      rd_bank_q, rd_bank_d;
   logic [1:0] full_q, full_d;
   logic       valid_q, valid_d;

   logic         wr_fire, rd_fire;
   logic [N-1:0] wr_re, wr_im;
   logic [3:0]   raddr0, raddr1;
   logic [2*N-1:0] rdata0, rdata1;

   assign o_ready = ~i_rst & ~full_q[wr_bank_q];
   assign wr_fire = i_valid & o_ready;
   assign rd_fire = valid_q & i_ready;

   always_comb begin
`ifdef FFT_LOADER_PRESCALE_EN
      wr_re = $signed(i_re) >>> 1;
      wr_im = $signed(i_im) >>> 1;
`else
      wr_re = i_re;
      wr_im = i_im;
`endif
   end

   // Writer only completes into an empty bank and reader only frees a full one,
   // so the two flag updates can never target the same bank in one cycle.
   always_comb begin
      wr_cnt_d  = wr_cnt_q;
      rd_cnt_d  = rd_cnt_q;
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      full_d    = full_q;
      if (wr_fire) begin
         wr_cnt_d = wr_cnt_q + 4'd1;
         if (wr_cnt_q == 4'd15) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = other_bank(wr_bank_q);
         end
      end
      if (rd_fire) begin
         rd_cnt_d = rd_cnt_q + 3'd1;
         if (rd_cnt_q == 3'd7) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = other_bank(rd_bank_q);
         end
      end
      valid_d = full_d[rd_bank_d];
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_cnt_q  <= '0;
         rd_cnt_q  <= '0;
         wr_bank_q <= BANK0;
         rd_bank_q <= BANK0;
         full_q    <= '0;
         valid_q   <= 1'b0;
      end else begin
         wr_cnt_q  <= wr_cnt_d;
         rd_cnt_q  <= rd_cnt_d;
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         full_q    <= full_d;
         valid_q   <= valid_d;
      end
   end

   assign raddr0 = bitrev4({rd_cnt_q, 1'b0});
   assign raddr1 = bitrev4({rd_cnt_q, 1'b1});

   fft16_pingpong_bank #(
      .W(2 * N)
   ) u_bank (
      .i_clk    (i_clk),
      .i_we     (wr_fire),
      .i_wbank  (wr_bank_q),
      .i_waddr  (wr_cnt_q),
      .i_wdata  ({wr_re, wr_im}),
      .i_rbank  (rd_bank_q),
      .i_raddr0 (raddr0),
      .i_raddr1 (raddr1),
      .o_rdata0 (rdata0),
      .o_rdata1 (rdata1)
   );

   assign o_valid      = valid_q;
   assign o_in0_re     = rdata0[2*N-1:N];
   assign o_in0_im     = rdata0[N-1:0];
   assign o_in1_re     = rdata1[2*N-1:N];
   assign o_in1_im     = rdata1[N-1:0];
   assign o_twiddle_re = W0_RE_L;
   assign o_twiddle_im = '0;
   assign o_pair_idx   = rd_cnt_q;
   assign o_last       = valid_q & (rd_cnt_q == 3'd7);

endmodule

// File: tb/tb_fft16_bitrev_loader.sv
// Self-checking bench for fft16_bitrev_loader against a frame/queue reference model.
module tb_fft16_bitrev_loader;

   logic        clk = 1'b0;
   logic        i_rst, i_valid, i_ready;
   logic [15:0] i_re, i_im;
   logic        o_ready, o_valid, o_last;
   logic [15:0] o_in0_re, o_in0_im, o_in1_re, o_in1_im, o_twiddle_re, o_twiddle_im;
   logic [2:0]  o_pair_idx;

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct {
      logic [63:0] data;
      int          k;
   } pair_t;

   pair_t       exp_q[$];
   logic [15:0] fre[16];
   logic [15:0] fim[16];
   int          wn = 0;

   always #5 clk = ~clk;

   fft16_bitrev_loader #(
      .N(16),
      .Q(8)
   ) dut (
      .i_clk        (clk),
      .i_rst        (i_rst),
      .i_valid      (i_valid),
      .o_ready      (o_ready),
      .i_re         (i_re),
      .i_im         (i_im),
      .o_valid      (o_valid),
      .i_ready      (i_ready),
      .o_in0_re     (o_in0_re),
      .o_in0_im     (o_in0_im),
      .o_in1_re     (o_in1_re),
      .o_in1_im     (o_in1_im),
      .o_twiddle_re (o_twiddle_re),
      .o_twiddle_im (o_twiddle_im),
      .o_pair_idx   (o_pair_idx),
      .o_last       (o_last)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int rev4(input int x);
      int r = 0;
      for (int i = 0; i < 4; i++)
         if ((x >> i) & 1) r = r | (1 << (3 - i));
      return r;
   endfunction

   function automatic logic [15:0] scale(input logic [15:0] v);
`ifdef FFT_LOADER_PRESCALE_EN
      return $signed(v) >>> 1;
`else
      return v;
`endif
   endfunction

   task automatic step(input logic v, input logic [15:0] re, input logic [15:0] im, input logic rdy);
      int    pend;
      logic  wf, rf;
      pair_t p;
      i_valid = v; i_re = re; i_im = im; i_ready = rdy;
      #1;
      pend = (exp_q.size() + 7) / 8;
      chk("valid", 64'(o_valid), 64'(pend > 0));
      chk("ready", 64'(o_ready), 64'(pend < 2));
      chk("twiddle", {o_twiddle_re, o_twiddle_im}, {16'd256, 16'd0});
      if (pend > 0) begin
         chk("pair", {o_in0_re, o_in0_im, o_in1_re, o_in1_im}, exp_q[0].data);
         chk("idx", 64'(o_pair_idx), 64'(exp_q[0].k));
         chk("last", 64'(o_last), 64'(exp_q[0].k == 7));
      end
      wf = v && (pend < 2);
      rf = (pend > 0) && rdy;
      @(posedge clk);
      if (rf) void'(exp_q.pop_front());
      if (wf) begin
         fre[wn] = scale(re);
         fim[wn] = scale(im);
         wn++;
         if (wn == 16) begin
            for (int k = 0; k < 8; k++) begin
               p.k    = k;
               p.data = {fre[rev4(2*k)], fim[rev4(2*k)], fre[rev4(2*k+1)], fim[rev4(2*k+1)]};
               exp_q.push_back(p);
            end
            wn = 0;
         end
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
      for (int c = 0; c < 2; c++) begin
         #1;
         chk("rst_valid", 64'(o_valid), 64'd0);
         chk("rst_ready", 64'(o_ready), 64'd0);
         chk("rst_idx", 64'(o_pair_idx), 64'd0);
         chk("rst_last", 64'(o_last), 64'd0);
         @(negedge clk);
      end
      i_rst = 1'b0;
      exp_q.delete();
      wn = 0;
   endtask

   initial begin
      i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_re = '0; i_im = '0;
      @(negedge clk);
      do_reset();

      // 1: ramp frame x[n]=(n,-n)
      for (int n = 0; n < 16; n++) step(1'b1, 16'(n), 16'(-n), 1'b0);
`ifndef FFT_LOADER_PRESCALE_EN
      chk("t1_pair0", {o_in0_re, o_in0_im, o_in1_re, o_in1_im}, 64'h0000_0000_0008_FFF8);
`endif
      for (int c = 0; c < 10; c++) step(1'b0, '0, '0, 1'b1);

      // 2: back-to-back frames
      for (int n = 0; n < 16; n++) step(1'b1, 16'($urandom), 16'($urandom), 1'b1);
      for (int n = 0; n < 16; n++) step(1'b1, 16'(100 + n), 16'd0, 1'b1);
      for (int c = 0; c < 12; c++) step(1'b0, '0, '0, 1'b1);

      // 3: downstream stalled with both banks loaded
      for (int n = 0; n < 36; n++) step(1'b1, 16'($urandom), 16'($urandom), 1'b0);
      for (int c = 0; c < 20; c++) step(1'b0, '0, '0, 1'b1);

      // 4: i_ready toggling
      for (int n = 0; n < 32; n++) step(1'b1, 16'($urandom), 16'($urandom), 1'(n & 1));
      for (int c = 0; c < 40; c++) step(1'b0, '0, '0, 1'(c & 1));

      // 5: reset mid-load, then mid-drain
      for (int n = 0; n < 9; n++) step(1'b1, 16'($urandom), 16'($urandom), 1'b1);
      do_reset();
      for (int n = 0; n < 16; n++) step(1'b1, 16'($urandom), 16'($urandom), 1'b0);
      for (int c = 0; c < 3; c++) step(1'b0, '0, '0, 1'b1);
      do_reset();
      for (int n = 0; n < 16; n++) step(1'b1, 16'($urandom), 16'($urandom), 1'b0);
      for (int c = 0; c < 10; c++) step(1'b0, '0, '0, 1'b1);

      // random traffic
      for (int c = 0; c < 600; c++)
         step(1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 2) != 0));
      for (int c = 0; c < 24; c++) step(1'b0, '0, '0, 1'b1);

      // 6: boundary values through the optional prescale path
      do_reset();
      for (int n = 0; n < 16; n++) begin
         if (n == 0)      step(1'b1, 16'hFFFD, 16'h0007, 1'b0);
         else if (n == 8) step(1'b1, 16'h7FFF, 16'h8000, 1'b0);
         else             step(1'b1, 16'($urandom), 16'($urandom), 1'b0);
      end
`ifdef FFT_LOADER_PRESCALE_EN
      chk("t6_pair0", {o_in0_re, o_in0_im, o_in1_re, o_in1_im}, 64'hFFFE_0003_3FFF_C000);
`else
      chk("t6_pair0", {o_in0_re, o_in0_im, o_in1_re, o_in1_im}, 64'hFFFD_0007_7FFF_8000);
`endif
      for (int c = 0; c < 10; c++) step(1'b0, '0, '0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
